// File: rtl/bb_cdr_loop_ctrl.sv
// Bang-bang CDR loop controller: vote decimation, P + saturating-I filter,
// wrapping phase-interpolator code and a lock detector. Optional macro GEAR_SHIFT_EN.
module bb_cdr_loop_ctrl #(
    parameter int PHASE_W    = 7,
    parameter int ACC_W      = 10,
    parameter int DECIM      = 8,
    parameter int KP         = 2,
    parameter int KI_SHIFT   = 4,
    parameter int LOCK_THR   = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    T,
    input  logic                    E,
    input  logic                    FREEZE,
    output logic [PHASE_W-1:0]      PHASE,
    output logic                    PHASE_UPD,
    output logic                    LOCK,
    output logic signed [ACC_W-1:0] INTEG,
    inout  wire                     VDD,
    inout  wire                     VSS
);
    localparam int WINW = $clog2(DECIM);
    localparam int SUMW = $clog2(DECIM) + 2;
    localparam int SW   = ((ACC_W > PHASE_W) ? ACC_W : PHASE_W) + 2;
    localparam int CNTW = $clog2(((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT) + 1);

    localparam logic signed [ACC_W:0]    IMAX = (ACC_W+1)'((1 <<< (ACC_W-1)) - 1);
    localparam logic signed [ACC_W:0]    IMIN = -IMAX;
    localparam logic signed [SUMW-1:0]   THR  = SUMW'(LOCK_THR);
    localparam logic signed [SW-1:0]     KP1  = SW'(KP);
    localparam logic signed [SW-1:0]     KP2  = SW'(2 * KP);

    // LOCK is the FSM state itself, so the state is always observable.
    typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [WINW-1:0]         win_q, win_d;
    logic signed [SUMW-1:0]  sum_q, sum_d;
    logic                    act_q, act_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic                    upd_q, upd_d;
    logic signed [ACC_W-1:0] integ_q, integ_d;
    logic [CNTW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [CNTW-1:0]         unlock_cnt_q, unlock_cnt_d;

    logic signed [SUMW-1:0]  vote, s_tot, mag;
    logic                    pos, neg, quiet, active;
    logic signed [ACC_W:0]   sgn_a, integ_sum;
    logic signed [ACC_W-1:0] integ_new;
    logic signed [SW-1:0]    integ_ext, kp_mag, p_term, step;

    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    always_comb begin
        vote      = T ? (E ? SUMW'(1) : '1) : '0;
        s_tot     = sum_q + vote;
        active    = act_q | T;
        neg       = s_tot[SUMW-1];
        pos       = !neg && (s_tot != '0);
        mag       = neg ? -s_tot : s_tot;
        quiet     = (mag <= THR);
        sgn_a     = pos ? (ACC_W+1)'(1) : (neg ? '1 : '0);
        integ_sum = {integ_q[ACC_W-1], integ_q} + sgn_a;
        if (integ_sum > IMAX)      integ_new = IMAX[ACC_W-1:0];
        else if (integ_sum < IMIN) integ_new = IMIN[ACC_W-1:0];
        else                       integ_new = integ_sum[ACC_W-1:0];
        integ_ext = {{(SW-ACC_W){integ_new[ACC_W-1]}}, integ_new};
`ifdef GEAR_SHIFT_EN
        kp_mag    = (state_q == ACQUIRE) ? KP2 : KP1;
`else
        kp_mag    = KP1;
`endif
        p_term    = pos ? kp_mag : (neg ? -kp_mag : '0);
        // Arithmetic shift of a signed value floors toward -inf.
        step      = p_term + (integ_ext >>> KI_SHIFT);

        state_d      = state_q;
        win_d        = win_q + WINW'(1);
        sum_d        = s_tot;
        act_d        = active;
        phase_d      = phase_q;
        upd_d        = 1'b0;
        integ_d      = integ_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;

        if (win_q == WINW'(DECIM - 1)) begin
            win_d = '0;
            sum_d = '0;
            act_d = 1'b0;
            if (!FREEZE) begin
                integ_d = integ_new;
                phase_d = phase_q + step[PHASE_W-1:0];
                upd_d   = (step != '0);
                // Windows with no transitions carry no lock information.
                if (active) begin
                    case (state_q)
                        ACQUIRE: begin
                            if (!quiet) begin
                                lock_cnt_d = '0;
                            end else if (lock_cnt_q == CNTW'(LOCK_CNT - 1)) begin
                                state_d      = LOCKED;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else begin
                                lock_cnt_d = lock_cnt_q + CNTW'(1);
                            end
                        end
                        LOCKED: begin
                            if (quiet) begin
                                unlock_cnt_d = '0;
                            end else if (unlock_cnt_q == CNTW'(UNLOCK_CNT - 1)) begin
                                state_d      = ACQUIRE;
                                lock_cnt_d   = '0;
                                unlock_cnt_d = '0;
                            end else begin
                                unlock_cnt_d = unlock_cnt_q + CNTW'(1);
                            end
                        end
                        default: state_d = ACQUIRE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ACQUIRE;
            win_q        <= '0;
            sum_q        <= '0;
            act_q        <= 1'b0;
            phase_q      <= '0;
            upd_q        <= 1'b0;
            integ_q      <= '0;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            sum_q        <= sum_d;
            act_q        <= act_d;
            phase_q      <= phase_d;
            upd_q        <= upd_d;
            integ_q      <= integ_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
        end
    end

    assign PHASE     = phase_q;
    assign PHASE_UPD = upd_q;
    assign LOCK      = (state_q == LOCKED);
    assign INTEG     = integ_q;
endmodule

// File: tb/tb_bb_cdr_loop_ctrl.sv
// Bench for bb_cdr_loop_ctrl: directed and random vote windows checked every
// cycle against an integer-arithmetic model of the loop.
module tb_bb_cdr_loop_ctrl;
    localparam int PHASE_W    = 7;
    localparam int ACC_W      = 10;
    localparam int DECIM      = 8;
    localparam int KP         = 2;
    localparam int KI_SHIFT   = 4;
    localparam int LOCK_THR   = 2;
    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;
    localparam int IMAX       = (1 << (ACC_W - 1)) - 1;
    localparam int PMOD       = 1 << PHASE_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    t_in = 1'b0;
    logic                    e_in = 1'b0;
    logic                    frz = 1'b0;
    logic [PHASE_W-1:0]      phase;
    logic                    phase_upd;
    logic                    lock;
    logic signed [ACC_W-1:0] integ;
    wire                     vdd;
    wire                     vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int m_phase, m_integ, m_upd, m_lock, m_lcnt, m_ucnt, m_pos, m_sum, m_act;

    bb_cdr_loop_ctrl dut (
        .CLK(clk), .RST(rst), .T(t_in), .E(e_in), .FREEZE(frz),
        .PHASE(phase), .PHASE_UPD(phase_upd), .LOCK(lock), .INTEG(integ),
        .VDD(vdd), .VSS(vss)
    );

    always #5 clk = ~clk;

    function automatic int floor_shift(input int a, input int sh);
        int d;
        d = 1 << sh;
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".phase"}, int'(phase), m_phase);
        check({tag, ".upd"},   int'(phase_upd), m_upd);
        check({tag, ".lock"},  int'(lock), m_lock);
        check({tag, ".integ"}, int'($signed(integ)), m_integ);
    endtask

    task automatic model_reset();
        m_phase = 0; m_integ = 0; m_upd = 0; m_lock = 0;
        m_lcnt = 0; m_ucnt = 0; m_pos = 0; m_sum = 0; m_act = 0;
    endtask

    task automatic model_step(input bit t, input bit e, input bit f);
        int v, s, kp, stp, mag;
        v = t ? (e ? 1 : -1) : 0;
        m_sum += v;
        m_act = m_act | int'(t);
        m_upd = 0;
        if (m_pos == DECIM - 1) begin
            if (!f) begin
                s = (m_sum > 0) ? 1 : ((m_sum < 0) ? -1 : 0);
                m_integ = m_integ + s;
                if (m_integ > IMAX)  m_integ = IMAX;
                if (m_integ < -IMAX) m_integ = -IMAX;
`ifdef GEAR_SHIFT_EN
                kp = m_lock ? KP : 2 * KP;
`else
                kp = KP;
`endif
                stp = s * kp + floor_shift(m_integ, KI_SHIFT);
                m_phase = ((m_phase + stp) % PMOD + PMOD) % PMOD;
                m_upd = (stp != 0);
                mag = (m_sum < 0) ? -m_sum : m_sum;
                if (m_act != 0) begin
                    if (!m_lock) begin
                        if (mag <= LOCK_THR) m_lcnt++;
                        else                 m_lcnt = 0;
                        if (m_lcnt == LOCK_CNT) begin
                            m_lock = 1; m_lcnt = 0; m_ucnt = 0;
                        end
                    end else begin
                        if (mag > LOCK_THR) m_ucnt++;
                        else                m_ucnt = 0;
                        if (m_ucnt == UNLOCK_CNT) begin
                            m_lock = 0; m_lcnt = 0; m_ucnt = 0;
                        end
                    end
                end
            end
            m_sum = 0; m_act = 0; m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic cycle(input bit t, input bit e, input bit f, input string tag);
        t_in = t; e_in = e; frz = f;
        @(posedge clk);
        model_step(t, e, f);
        #1;
        check_all(tag);
    endtask

    // mode: 0 idle, 1 early, 2 late, 3 toggling, 4 random, 5 mostly early
    task automatic run_window(input int mode, input bit f, input string tag);
        bit t, e;
        for (int i = 0; i < DECIM; i++) begin
            case (mode)
                0:       begin t = 1'b0; e = 1'b0; end
                1:       begin t = 1'b1; e = 1'b1; end
                2:       begin t = 1'b1; e = 1'b0; end
                3:       begin t = 1'b1; e = i[0]; end
                4:       begin t = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1)); end
                default: begin t = 1'b1; e = ($urandom_range(0, 3) != 0); end
            endcase
            cycle(t, e, f, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset("reset");

        run_window(1, 1'b0, "first_win");
        check("first_win.integ_one", int'($signed(integ)), 1);
        for (int w = 0; w < 15; w++) run_window(1, 1'b0, "early16");
        check("early16.integ", int'($signed(integ)), 16);

        for (int w = 0; w < LOCK_CNT; w++) run_window(3, 1'b0, "quiet");
        check("quiet.lock_up", int'(lock), 1);
        for (int w = 0; w < UNLOCK_CNT; w++) run_window(1, 1'b0, "loud");
        check("loud.lock_down", int'(lock), 0);

        for (int w = 0; w < IMAX + 8; w++) run_window(1, 1'b0, "sat_pos");
        check("sat_pos.integ", int'($signed(integ)), IMAX);
        for (int w = 0; w < 2 * IMAX + 8; w++) run_window(2, 1'b0, "sat_neg");
        check("sat_neg.integ", int'($signed(integ)), -IMAX);

        for (int w = 0; w < 3; w++) run_window(1, 1'b1, "freeze");
        run_window(1, 1'b0, "unfreeze");
        run_window(0, 1'b0, "idle");

        for (int w = 0; w < 300; w++)
            run_window(int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), "random");

        for (int w = 0; w < LOCK_CNT + 1; w++) run_window(3, 1'b0, "relock");
        check("relock.lock", int'(lock), 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, i[0], 1'b0, "partial");
        do_reset("mid_reset");
        run_window(1, 1'b0, "post_reset");
        check("post_reset.integ", int'($signed(integ)), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
